// File: rtl/adc_conversion_sequencer.sv
// adc_conversion_sequencer: settles, captures and averages a 4-comparator flash ADC code, returns it over valid/ready.
// Optional BUBBLE_CORRECT_EN: illegal thermometer codes contribute max(ones-1,0) instead of 0.
module adc_conversion_sequencer #(
  parameter int SETTLE_CYCLES = 4,
  parameter int AVG_LOG2 = 2,
  parameter int PERIOD_CYCLES = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       continuous,
  input  logic [3:0] comp_in,
  output logic       comp_en,
  output logic       busy,
  output logic [1:0] result,
  output logic       result_valid,
  input  logic       result_ready,
  output logic       code_err,
  output logic       overrun,
  input  logic       clear_flags
);
  localparam int SW = $clog2(SETTLE_CYCLES + 2);
  localparam int NW = AVG_LOG2 + 1;
  localparam int AW = AVG_LOG2 + 2;
  localparam int PW = $clog2(PERIOD_CYCLES + 1) + 1;
  localparam int PT = PERIOD_CYCLES > 1 ? PERIOD_CYCLES - 1 : 0;
  typedef enum logic [1:0] {IDLE, SAMPLE, LOAD, GAP} state_t;
  state_t state_q, state_d;
  logic [3:0] sync1_q, sync2_q;
  logic [SW-1:0] scnt_q, scnt_d;
  logic [NW-1:0] ncnt_q, ncnt_d;
  logic [AW-1:0] acc_q, acc_d;
  logic [PW-1:0] pcnt_q, pcnt_d;
  logic [1:0] result_q, result_d;
  logic valid_q, valid_d, code_err_q, code_err_d, overrun_q, overrun_d;
  logic [2:0] ones;
  logic [1:0] val;
  logic legal, sampling, capture, last, due;
  assign ones = 3'($countones(sync2_q));
  assign legal = ((sync2_q + 4'd1) & sync2_q) == 4'd0;
`ifdef BUBBLE_CORRECT_EN
  assign val = ones == 3'd0 ? 2'd0 : 2'(ones - 3'd1);
`else
  assign val = (!legal || ones == 3'd0) ? 2'd0 : 2'(ones - 3'd1);
`endif
  assign sampling = state_q == SAMPLE;
  assign capture = sampling && scnt_q == SW'(SETTLE_CYCLES + 1);
  assign last = capture && ncnt_q == NW'((1 << AVG_LOG2) - 1);
  // pcnt_q counts cycles since the current burst's start edge
  assign due = pcnt_q >= PW'(PT);
  assign comp_en = sampling;
  assign busy = sampling || state_q == LOAD;
  assign result = result_q;
  assign result_valid = valid_q;
  assign code_err = code_err_q;
  assign overrun = overrun_q;
  always_comb begin
    scnt_d = (!sampling || capture) ? '0 : scnt_q + 1'b1;
    ncnt_d = sampling ? ncnt_q + NW'(capture) : '0;
    acc_d = sampling ? acc_q + (capture ? AW'(val) : '0) : '0;
    pcnt_d = due ? pcnt_q : pcnt_q + 1'b1;
    result_d = state_q == LOAD ? acc_q[AW-1:AVG_LOG2] : result_q;
    valid_d = state_q == LOAD ? 1'b1 : valid_q & ~result_ready;
    code_err_d = (capture & ~legal) | (code_err_q & ~clear_flags);
    overrun_d = (state_q == LOAD & valid_q & ~result_ready) | (overrun_q & ~clear_flags);
    state_d = state_q == IDLE   ? ((start || continuous) ? SAMPLE : IDLE) :
              state_q == SAMPLE ? (last ? LOAD : SAMPLE) :
              !continuous       ? IDLE :
              due               ? SAMPLE : GAP;
    if (!sampling && state_d == SAMPLE) pcnt_d = '0;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      sync1_q <= '0;
      sync2_q <= '0;
      scnt_q <= '0;
      ncnt_q <= '0;
      acc_q <= '0;
      pcnt_q <= '0;
      result_q <= '0;
      valid_q <= 1'b0;
      code_err_q <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sync1_q <= comp_in;
      sync2_q <= sync1_q;
      scnt_q <= scnt_d;
      ncnt_q <= ncnt_d;
      acc_q <= acc_d;
      pcnt_q <= pcnt_d;
      result_q <= result_d;
      valid_q <= valid_d;
      code_err_q <= code_err_d;
      overrun_q <= overrun_d;
    end
endmodule

// File: tb/tb_adc_conversion_sequencer.sv
// tb_adc_conversion_sequencer: randomized scoreboard bench for adc_conversion_sequencer (default parameters).
module tb_adc_conversion_sequencer;
  logic clk = 1'b0;
  logic rst_n, start, continuous, result_ready, clear_flags;
  logic [3:0] comp_in;
  logic comp_en, busy, result_valid, code_err, overrun;
  logic [1:0] result;
  int n_chk = 0;
  int n_fail = 0;
  bit err_m = 0;
  logic [1:0] exp_q[$];

  adc_conversion_sequencer dut (
    .clk(clk), .rst_n(rst_n), .start(start), .continuous(continuous),
    .comp_in(comp_in), .comp_en(comp_en), .busy(busy), .result(result),
    .result_valid(result_valid), .result_ready(result_ready),
    .code_err(code_err), .overrun(overrun), .clear_flags(clear_flags)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Reference decode: ones-count minus one, floored at zero; illegal codes give 0 unless bubble-corrected
  function automatic bit is_legal(input logic [3:0] c);
    return c == 4'h0 || c == 4'h1 || c == 4'h3 || c == 4'h7 || c == 4'hF;
  endfunction

  function automatic int dec(input logic [3:0] c);
    int n;
    n = $countones(c);
`ifdef BUBBLE_CORRECT_EN
    return n > 0 ? n - 1 : 0;
`else
    return (is_legal(c) && n > 0) ? n - 1 : 0;
`endif
  endfunction

  function automatic logic [1:0] avg(input logic [15:0] codes);
    int s;
    s = 0;
    for (int k = 0; k < 4; k++) s += dec(codes[4*k +: 4]);
    return 2'(s / 4);
  endfunction

  function automatic logic [3:0] rcode(input bit allow_bad);
    logic [3:0] c;
    c = 4'((1 << $urandom_range(0, 4)) - 1);
    if (allow_bad && $urandom_range(0, 3) == 0) c = 4'($urandom);
    return c;
  endfunction

  function automatic logic [15:0] rburst(input bit allow_bad);
    logic [15:0] v;
    for (int k = 0; k < 4; k++) v[4*k +: 4] = rcode(allow_bad);
    return v;
  endfunction

  // Monitor: sample just before each rising edge; a valid&ready cycle is one accepted result
  always @(negedge clk) begin
    #4;
    if (rst_n && result_valid && result_ready) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_result: got %0d expected none", result);
      end else check("result", result, exp_q.pop_front());
    end
  end

  task automatic clear_pulse();
    clear_flags = 1'b1;
    @(negedge clk);
    clear_flags = 1'b0;
    err_m = 0;
    check("flags_cleared", {code_err, overrun}, 0);
  endtask

  // Single-shot burst; j indexes the falling edges after the start edge E0
  task automatic burst(input logic [15:0] codes, input int hold);
    int en_cnt;
    en_cnt = 0;
    for (int k = 0; k < 4; k++) if (!is_legal(codes[4*k +: 4])) err_m = 1;
    exp_q.push_back(avg(codes));
    result_ready = 1'b0;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    for (int j = 0; j <= 25; j++) begin
      if (j % 6 == 0 && j < 24) comp_in = codes[4*(j/6) +: 4];
      en_cnt += int'(comp_en);
      if (j == 1) check("busy_in_burst", busy, 1);
      if (j == 24) check("valid_not_early", result_valid, 0);
      if (j == 25) begin
        check("valid_latency", result_valid, 1);
        check("code_err", code_err, err_m);
      end
      if (j < 25) @(negedge clk);
    end
    check("comp_en_cycles", en_cnt, 24);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check("valid_hold", {result_valid, result}, {1'b1, avg(codes)});
    end
    result_ready = 1'b1;
    @(negedge clk);
    check("valid_cleared", {result_valid, busy}, 0);
  endtask

  // Free-running run: bursts start every 32 cycles, continuous drops at drop_j
  task automatic cont_run(input bit rdy, input int drop_j, input int nb);
    logic [47:0] codes;
    int en_after;
    codes = {rburst(0), rburst(0), rburst(0)};
    en_after = 0;
    if (rdy) for (int b = 0; b < nb; b++) exp_q.push_back(avg(codes[16*b +: 16]));
    else exp_q.push_back(avg(codes[16*(nb-1) +: 16]));
    result_ready = rdy;
    continuous = 1'b1;
    @(posedge clk);
    @(negedge clk);
    for (int j = 0; j < 130; j++) begin
      if (j % 32 < 24 && (j % 32) % 6 == 0 && j / 32 < 3) comp_in = codes[16*(j/32) + 4*((j%32)/6) +: 4];
      if (j == drop_j) continuous = 1'b0;
      if (j >= 32*(nb-1) + 24) en_after += int'(comp_en | busy);
      if (j == 28) check("gap_idle", {comp_en, busy}, 0);
      if (j == 33) check("second_burst", comp_en, 1);
      if (!rdy && j == 25) check("first_result", {result_valid, result}, {1'b1, avg(codes[15:0])});
      if (j == 56) check("overrun_before", overrun, 0);
      if (j == 57) check("second_load", {result_valid, overrun, result},
                         {1'b1, ~rdy, avg(codes[31:16])});
      @(negedge clk);
    end
    check("quiet_after_drop", en_after, 1);
    result_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("drained", result_valid, 0);
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    continuous = 1'b0;
    comp_in = '0;
    result_ready = 1'b0;
    clear_flags = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_outputs", {comp_en, busy, result_valid, result, code_err, overrun}, 0);
    rst_n = 1'b1;
    @(negedge clk);
    burst(16'h7777, 0);
    burst({4'hF, 4'h7, 4'h7, 4'h3}, 2);
    burst({4'h3, 4'h3, 4'h1, 4'h1}, 1);
    burst({4'hF, 4'hF, 4'h5, 4'hF}, 0);
    clear_pulse();
    for (int i = 0; i < 12; i++) begin
      burst(rburst(1), int'($urandom_range(0, 3)));
      if ($urandom_range(0, 1) == 1) clear_pulse();
    end
    // Asynchronous reset in the middle of a burst that has captured an illegal code
    result_ready = 1'b0;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    comp_in = 4'h5;
    repeat (8) @(negedge clk);
    check("pre_reset", {comp_en, code_err}, 2'b11);
    #2 rst_n = 1'b0;
    #1 check("async_reset", {comp_en, busy, result_valid, result, code_err, overrun}, 0);
    err_m = 0;
    @(negedge clk);
    rst_n = 1'b1;
    comp_in = '0;
    repeat (3) @(negedge clk);
    check("idle_after_reset", {comp_en, busy, result_valid}, 0);
    cont_run(0, 40, 2);
    clear_pulse();
    cont_run(1, 70, 3);
    check("queue_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/adc_conversion_sequencer.md
Name: adc_conversion_sequencer

Overview:
Controls the 4-comparator flash ADC front end. It enables the comparators and waits for them to settle. It then synchronises and captures the thermometer code, checks that the code is legal, and averages 2^AVG_LOG2 samples per conversion. It returns a 2-bit result over a valid/ready handshake to the digital core, in single-shot or free-running (continuous) mode.

Parameters:
- SETTLE_CYCLES, 4: cycles comp_en is high before each capture, excluding synchroniser delay; legal range >=1.
- AVG_LOG2, 2: samples averaged per conversion = 2^AVG_LOG2; legal range 0..4.
- PERIOD_CYCLES, 32: continuous mode only; cycles from one burst start to the next. If it is below the burst length, the next burst starts back-to-back.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  single-shot conversion request (level sampled; ignored while busy)
- continuous  in  1  1 = free-running conversions
- comp_in  in  4  raw thermometer code from comparators (asynchronous to clk)
- comp_en  out  1  comparator/reference enable
- busy  out  1  a burst is in progress
- result  out  2  averaged conversion result
- result_valid  out  1  result available
- result_ready  in  1  consumer accepts result
- code_err  out  1  sticky: illegal thermometer code captured
- overrun  out  1  sticky: unaccepted result overwritten
- clear_flags  in  1  synchronous clear of code_err and overrun

Behaviour:
- Reset (async, rst_n=0): all outputs 0; FSM goes to IDLE; accumulator, counters and synchroniser flops are cleared. comp_en drops immediately, including mid-burst.
- comp_in passes through a free-running 2-flop synchroniser. Only the synchronised value is used.
- Decode (value = ones-count minus 1, floor 0): 0000->0, 0001->0, 0011->1, 0111->2, 1111->3. Any other code is illegal: it sets code_err and contributes value 0.
- FSM states: IDLE, SAMPLE, LOAD, GAP.
- IDLE: comp_en=0, busy=0. If (start or continuous) is sampled at edge E0, go to SAMPLE. Clear the accumulator and sample count.
- SAMPLE: comp_en=1, busy=1.
  - Each sample occupies SETTLE_CYCLES+2 cycles.
  - On its last edge, the decoded synchronised code is added into the accumulator (width 2+AVG_LOG2 bits; no overflow is possible) and the sample count increments.
  - comp_en stays high across all samples of a burst.
  - After the 2^AVG_LOG2-th capture, go to LOAD; comp_en falls after that edge.
- LOAD (1 cycle): result <= accumulator >> AVG_LOG2 (truncating), result_valid <= 1.
  - Then go to GAP if continuous=1, else IDLE.
  - Latency: result_valid rises at edge E0 + 2^AVG_LOG2*(SETTLE_CYCLES+2) + 1. With defaults this is E0+25.
- GAP: busy=0, comp_en=0. Wait until PERIOD_CYCLES have elapsed since E0, then go to SAMPLE.
  - If continuous is deasserted while in GAP, go to IDLE.
  - If continuous is deasserted mid-burst, the burst completes and delivers its result, then the FSM goes to IDLE.
- Handshake:
  - result and result_valid hold stable until a cycle with result_valid & result_ready; then result_valid clears at that edge.
  - LOAD while result_valid=1 and result_ready=0: result is overwritten and overrun is set.
  - LOAD in the same cycle as an accept: no overrun; result_valid stays 1 with the new value.
- Sticky flags: clear_flags clears them at the next edge. A set and a clear in the same cycle leaves the flag set.
- start asserted while busy: ignored, not queued. start held high in IDLE after a single-shot starts another conversion.

Optional Feature:
BUBBLE_CORRECT_EN.
- Defined: illegal codes still set code_err, but contribute max(ones-count minus 1, 0) rather than 0. Example: 0101 -> 1, 1011 -> 2.
- Undefined: illegal codes contribute 0.

Test Plan:
- Reset mid-burst: rst_n low during SAMPLE -> comp_en, busy, result_valid, result, flags all 0 asynchronously; FSM is IDLE after release.
- Single-shot, defaults, comp_in held 0111, start pulse at E0 -> comp_en high E0..E0+24, result_valid at E0+25, result=2; result_ready=1 clears result_valid next edge; FSM returns to IDLE.
- Averaging: captured samples 0011, 0111, 0111, 1111 -> sum 8, result=2; with samples 0001, 0001, 0011, 0011 -> result=0 (truncation of 2/4).
- Illegal code 0101 in one of four samples, others 1111 -> code_err=1; result=2 (9>>2) without macro, result=2 (10>>2) with BUBBLE_CORRECT_EN; clear_flags -> code_err=0.
- Continuous, PERIOD_CYCLES=32, result_ready=0 -> second LOAD at E0+57 sets overrun=1 and updates result. Repeat with result_ready=1 on the LOAD cycle -> overrun stays 0.
- Continuous dropped during SAMPLE -> burst completes, result delivered, FSM returns to IDLE with no further comp_en activity.
